// File: rtl/pc_sequencer.sv
// Fetch-stage PC sequencer: owns the program counter, sequences imem req/ack fetches.
// Optional PC_SEQ_PERF_EN adds redirect and stall performance counters.
module pc_sequencer #(
  parameter logic [31:0] RESET_PC   = 32'h0040_0020,
  parameter logic [31:0] EXC_VECTOR = 32'h8000_0180,
  parameter int unsigned INSTR_W    = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               stall_f,
  input  logic               branch_taken_d,
  input  logic [31:0]        branch_target_d,
  input  logic               jump_d,
  input  logic [31:0]        jump_target_d,
  input  logic               exc_req,
  output logic               imem_req,
  output logic [31:0]        imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [31:0]        pc_f,
  output logic [31:0]        pc_plus4_f,
  output logic [INSTR_W-1:0] instr_f,
  output logic               fetch_valid,
  output logic               flush_d
`ifdef PC_SEQ_PERF_EN
  ,
  output logic [31:0]        redirect_count,
  output logic [31:0]        stall_count
`endif
);

  typedef enum logic [1:0] {StIdle, StReq, StDrain, StHold} state_e;

  state_e             state_q, state_d;
  logic [31:0]        pc_q, pc_d;
  logic [31:0]        pending_q, pending_d;
  logic [INSTR_W-1:0] hold_q, hold_d;

  logic        redirect;
  logic [31:0] target_raw;
  logic [31:0] target;

  assign redirect = exc_req | jump_d | branch_taken_d;

  always_comb begin
    if (exc_req) begin
      target_raw = EXC_VECTOR;
    end else if (jump_d) begin
      target_raw = jump_target_d;
    end else begin
      target_raw = branch_target_d;
    end
  end

  assign target = {target_raw[31:2], 2'b00};

  assign pc_f       = pc_q;
  assign pc_plus4_f = pc_q + 32'd4;
  // The address tracks pc_q, which only moves on ack or while no request is open.
  assign imem_addr  = pc_q;
  assign flush_d    = redirect & rst_n;

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    pending_d   = pending_q;
    hold_d      = hold_q;
    imem_req    = 1'b0;
    fetch_valid = 1'b0;
    instr_f     = '0;

    case (state_q)
      StIdle: begin
        state_d = StReq;
        if (redirect) begin
          pc_d = target;
        end
      end

      StReq: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          if (redirect) begin
            pc_d = target;
          end else if (stall_f) begin
            hold_d  = imem_rdata;
            state_d = StHold;
          end else begin
            fetch_valid = 1'b1;
            instr_f     = imem_rdata;
            pc_d        = pc_plus4_f;
          end
        end else if (redirect) begin
          pending_d = target;
          state_d   = StDrain;
        end
      end

      StDrain: begin
        // Wrong-path request still open; its response is thrown away.
        imem_req = 1'b1;
        if (imem_ack) begin
          pc_d    = redirect ? target : pending_q;
          state_d = StReq;
        end else if (redirect) begin
          pending_d = target;
        end
      end

      StHold: begin
        if (redirect) begin
          hold_d  = '0;
          pc_d    = target;
          state_d = StReq;
        end else if (!stall_f) begin
          fetch_valid = 1'b1;
          instr_f     = hold_q;
          pc_d        = pc_plus4_f;
          state_d     = StReq;
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      pc_q      <= RESET_PC;
      pending_q <= '0;
      hold_q    <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      pending_q <= pending_d;
      hold_q    <= hold_d;
    end
  end

`ifdef PC_SEQ_PERF_EN
  logic [31:0] redirect_cnt_q;
  logic [31:0] stall_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      redirect_cnt_q <= '0;
      stall_cnt_q    <= '0;
    end else begin
      if (redirect) begin
        redirect_cnt_q <= redirect_cnt_q + 32'd1;
      end
      if ((state_q == StHold) || (state_q == StDrain)) begin
        stall_cnt_q <= stall_cnt_q + 32'd1;
      end
    end
  end

  assign redirect_count = redirect_cnt_q;
  assign stall_count    = stall_cnt_q;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed scenarios plus random traffic vs a fetch model.
// Build with PC_SEQ_PERF_EN defined to also check the performance counters.
module tb_pc_sequencer;

  localparam logic [31:0] RESET_PC   = 32'h0040_0020;
  localparam logic [31:0] EXC_VECTOR = 32'h8000_0180;
  localparam int unsigned INSTR_W    = 32;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               stall_f = 1'b0;
  logic               branch_taken_d = 1'b0;
  logic [31:0]        branch_target_d = '0;
  logic               jump_d = 1'b0;
  logic [31:0]        jump_target_d = '0;
  logic               exc_req = 1'b0;
  logic               imem_req;
  logic [31:0]        imem_addr;
  logic               imem_ack = 1'b0;
  logic [INSTR_W-1:0] imem_rdata = '0;
  logic [31:0]        pc_f;
  logic [31:0]        pc_plus4_f;
  logic [INSTR_W-1:0] instr_f;
  logic               fetch_valid;
  logic               flush_d;
`ifdef PC_SEQ_PERF_EN
  logic [31:0]        redirect_count;
  logic [31:0]        stall_count;
`endif

  pc_sequencer #(
    .RESET_PC  (RESET_PC),
    .EXC_VECTOR(EXC_VECTOR),
    .INSTR_W   (INSTR_W)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .stall_f        (stall_f),
    .branch_taken_d (branch_taken_d),
    .branch_target_d(branch_target_d),
    .jump_d         (jump_d),
    .jump_target_d  (jump_target_d),
    .exc_req        (exc_req),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ack       (imem_ack),
    .imem_rdata     (imem_rdata),
    .pc_f           (pc_f),
    .pc_plus4_f     (pc_plus4_f),
    .instr_f        (instr_f),
    .fetch_valid    (fetch_valid),
    .flush_d        (flush_d)
`ifdef PC_SEQ_PERF_EN
    ,
    .redirect_count (redirect_count),
    .stall_count    (stall_count)
`endif
  );

  always #5 clk = ~clk;

  int   n_vec = 0;
  int   n_err = 0;
  logic chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] redirect_target();
    logic [31:0] t;
    t = exc_req ? EXC_VECTOR : (jump_d ? jump_target_d : branch_target_d);
    return t & 32'hFFFF_FFFC;
  endfunction

  function automatic logic any_redirect();
    return exc_req | jump_d | branch_taken_d;
  endfunction

  // Fetch model: "live" once the post-reset idle cycle is over; a held word parks the
  // fetch stream; "drain" means an outstanding wrong-path request still owes an ack.
  logic [31:0]        m_pc;
  logic               m_live;
  logic               m_held;
  logic [INSTR_W-1:0] m_word;
  logic               m_drain;
  logic [31:0]        m_pend;
`ifdef PC_SEQ_PERF_EN
  logic [31:0]        m_rc;
  logic [31:0]        m_sc;
`endif

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_pc    <= RESET_PC;
      m_live  <= 1'b0;
      m_held  <= 1'b0;
      m_word  <= '0;
      m_drain <= 1'b0;
      m_pend  <= '0;
`ifdef PC_SEQ_PERF_EN
      m_rc    <= '0;
      m_sc    <= '0;
`endif
    end else begin
`ifdef PC_SEQ_PERF_EN
      if (any_redirect()) m_rc <= m_rc + 1;
      if (m_held || m_drain) m_sc <= m_sc + 1;
`endif
      if (!m_live) begin
        m_live <= 1'b1;
        if (any_redirect()) m_pc <= redirect_target();
      end else if (m_held) begin
        if (any_redirect()) begin
          m_held <= 1'b0;
          m_pc   <= redirect_target();
        end else if (!stall_f) begin
          m_held <= 1'b0;
          m_pc   <= m_pc + 32'd4;
        end
      end else if (m_drain) begin
        if (imem_ack) begin
          m_drain <= 1'b0;
          m_pc    <= any_redirect() ? redirect_target() : m_pend;
        end else if (any_redirect()) begin
          m_pend <= redirect_target();
        end
      end else if (imem_ack) begin
        if (any_redirect()) m_pc <= redirect_target();
        else if (stall_f) begin
          m_held <= 1'b1;
          m_word <= imem_rdata;
        end else m_pc <= m_pc + 32'd4;
      end else if (any_redirect()) begin
        m_drain <= 1'b1;
        m_pend  <= redirect_target();
      end
    end
  end

  always @(negedge clk) begin : cmp
    logic               e_req;
    logic               e_valid;
    logic [INSTR_W-1:0] e_instr;
    if (rst_n && chk_en) begin
      e_req   = m_live && !m_held;
      e_valid = m_live && !any_redirect() && !stall_f &&
                (m_held || (!m_drain && imem_ack));
      e_instr = m_held ? m_word : imem_rdata;
      check("imem_req", {31'b0, imem_req}, {31'b0, e_req});
      if (e_req) check("imem_addr", imem_addr, m_pc);
      check("pc_f", pc_f, m_pc);
      check("pc_plus4_f", pc_plus4_f, m_pc + 32'd4);
      check("flush_d", {31'b0, flush_d}, {31'b0, any_redirect()});
      check("fetch_valid", {31'b0, fetch_valid}, {31'b0, e_valid});
      if (e_valid) check("instr_f", instr_f, e_instr);
`ifdef PC_SEQ_PERF_EN
      check("redirect_count", redirect_count, m_rc);
      check("stall_count", stall_count, m_sc);
`endif
    end
  end

  task automatic at_neg();
    @(negedge clk);
    #1;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_redirects();
    branch_taken_d = 1'b0;
    jump_d         = 1'b0;
    exc_req        = 1'b0;
  endtask

  initial begin
    #12;
    check("rst imem_req", {31'b0, imem_req}, 32'd0);
    check("rst fetch_valid", {31'b0, fetch_valid}, 32'd0);
    check("rst flush_d", {31'b0, flush_d}, 32'd0);
    check("rst instr_f", instr_f, 32'd0);
    check("rst pc_f", pc_f, 32'h0040_0020);
    next_cycle();
    rst_n  = 1'b1;
    chk_en = 1'b1;

    // Back-to-back fetch with same-cycle ack.
    imem_ack   = 1'b1;
    imem_rdata = $urandom;
    at_neg();
    check("idle req", {31'b0, imem_req}, 32'd0);
    next_cycle();
    for (int i = 0; i < 3; i++) begin
      at_neg();
      check("seq addr", imem_addr, 32'h0040_0020 + 32'(4 * i));
      check("seq valid", {31'b0, fetch_valid}, 32'd1);
      next_cycle();
      imem_rdata = $urandom;
    end

    // Stall at ack parks the word; stray acks in HOLD are ignored.
    imem_rdata = 32'h8C01_0004;
    stall_f    = 1'b1;
    at_neg();
    check("stall ack valid", {31'b0, fetch_valid}, 32'd0);
    next_cycle();
    imem_rdata = 32'hDEAD_BEEF;
    for (int i = 0; i < 3; i++) begin
      at_neg();
      check("hold req", {31'b0, imem_req}, 32'd0);
      check("hold valid", {31'b0, fetch_valid}, 32'd0);
      next_cycle();
    end
    stall_f  = 1'b0;
    imem_ack = 1'b0;
    at_neg();
    check("hold release valid", {31'b0, fetch_valid}, 32'd1);
    check("hold release instr", instr_f, 32'h8C01_0004);
    next_cycle();
    at_neg();
    check("post hold addr", imem_addr, 32'h0040_0030);
    next_cycle();

    // Branch with a late ack goes through DRAIN.
    branch_taken_d  = 1'b1;
    branch_target_d = 32'h0040_0100;
    at_neg();
    check("branch flush", {31'b0, flush_d}, 32'd1);
    next_cycle();
    clear_redirects();
    at_neg();
    check("drain flush", {31'b0, flush_d}, 32'd0);
    check("drain addr", imem_addr, 32'h0040_0030);
    next_cycle();
    imem_ack   = 1'b1;
    imem_rdata = 32'h1234_5678;
    at_neg();
    check("drain discard", {31'b0, fetch_valid}, 32'd0);
    next_cycle();
    imem_ack = 1'b0;
    at_neg();
    check("branch target addr", imem_addr, 32'h0040_0100);
`ifdef PC_SEQ_PERF_EN
    check("redirect_count", redirect_count, 32'd1);
`endif
    next_cycle();

    // All three redirect sources at once: exception wins.
    exc_req         = 1'b1;
    jump_d          = 1'b1;
    jump_target_d   = 32'h0040_0200;
    branch_taken_d  = 1'b1;
    branch_target_d = 32'h0040_0104;
    imem_ack        = 1'b1;
    at_neg();
    next_cycle();
    clear_redirects();
    imem_ack = 1'b0;
    at_neg();
    check("exc priority pc", pc_f, 32'h8000_0180);
    next_cycle();

    // Misaligned target near the top of memory, then wrap.
    jump_d        = 1'b1;
    jump_target_d = 32'hFFFF_FFFE;
    imem_ack      = 1'b1;
    at_neg();
    next_cycle();
    clear_redirects();
    imem_ack = 1'b0;
    at_neg();
    check("top addr", imem_addr, 32'hFFFF_FFFC);
    check("top pc_plus4", pc_plus4_f, 32'h0000_0000);
    next_cycle();
    imem_ack = 1'b1;
    at_neg();
    check("top valid", {31'b0, fetch_valid}, 32'd1);
    next_cycle();
    imem_ack = 1'b0;
    at_neg();
    check("wrap addr", imem_addr, 32'h0000_0000);
    next_cycle();

    // Asynchronous reset while draining drops the pending redirect.
    branch_taken_d  = 1'b1;
    branch_target_d = 32'h0040_0300;
    at_neg();
    next_cycle();
    clear_redirects();
    at_neg();
    rst_n = 1'b0;
    #1;
    check("async rst req", {31'b0, imem_req}, 32'd0);
    check("async rst pc", pc_f, 32'h0040_0020);
    next_cycle();
    rst_n = 1'b1;
    at_neg();
    check("post rst idle", {31'b0, imem_req}, 32'd0);
    next_cycle();
    at_neg();
    check("post rst addr", imem_addr, 32'h0040_0020);
    next_cycle();

    // Random traffic against the model.
    for (int i = 0; i < 4000; i++) begin
      stall_f         = ($urandom_range(0, 3) == 0);
      imem_ack        = ($urandom_range(0, 1) == 1);
      imem_rdata      = $urandom;
      branch_taken_d  = ($urandom_range(0, 9) == 0);
      branch_target_d = $urandom;
      jump_d          = ($urandom_range(0, 14) == 0);
      jump_target_d   = $urandom;
      exc_req         = ($urandom_range(0, 39) == 0);
      next_cycle();
    end
    clear_redirects();
    at_neg();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
